pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: derives stall/bubble controls for a five-stage
// Y86-style pipeline from the D/E/M/W stage contents, sequences the fixed
// fetch stall that follows a ret, halts on write-back exceptions and keeps
// saturating stall/bubble performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned RET_WAIT_CYCLES = 3,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode_d,
  input  logic [3:0]       icode_e,
  input  logic [3:0]       icode_m,
  input  logic [3:0]       srcA_d,
  input  logic [3:0]       srcB_d,
  input  logic [3:0]       dstM_e,
  input  logic             cnd_e,
  input  logic [2:0]       stat_m,
  input  logic [2:0]       stat_w,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_d,
  output logic             bubble_e,
  output logic             bubble_m,
  output logic             stall_w,
  output logic             cc_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [2:0] S_AOK    = 3'd1;

  // The ret cycle seen in RUN is the first stall cycle; RET_WAIT covers the rest.
  localparam bit         RET_MULTI = (RET_WAIT_CYCLES > 1);
  localparam logic [3:0] RET_LOAD  = 4'(RET_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t     state_q, state_nx;
  logic [3:0] ret_cnt_q, ret_cnt_nx;

  logic load_use, mispredict, ret_d, m_exc, w_exc;

  // icode_m is part of the pipeline-register view but no rule depends on it.
  logic unused_icode_m;
  assign unused_icode_m = ^icode_m;

  // Hazard condition terms from the current pipeline contents.
  always_comb begin
    load_use   = ((icode_e == I_MRMOVQ) || (icode_e == I_POPQ)) &&
                 (dstM_e != R_NONE) &&
                 ((dstM_e == srcA_d) || (dstM_e == srcB_d));
    mispredict = (icode_e == I_JXX) && !cnd_e;
    ret_d      = (icode_d == I_RET);
    m_exc      = (stat_m != S_AOK);
    w_exc      = (stat_w != S_AOK);
  end

  // Mealy control outputs and next-state/ret-countdown selection.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    bubble_d   = 1'b0;
    bubble_e   = 1'b0;
    bubble_m   = m_exc | w_exc;
    stall_w    = w_exc;
    cc_en      = ~(m_exc | w_exc);
    state_nx   = state_q;
    ret_cnt_nx = ret_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        stall_f  = load_use | ret_d;
        stall_d  = load_use;
        bubble_d = mispredict | (ret_d & ~load_use);
        bubble_e = mispredict | load_use;
        if (w_exc) begin
          state_nx   = ST_HALTED;
          ret_cnt_nx = '0;
        end else if (RET_MULTI && ret_d && !load_use && !mispredict) begin
          state_nx   = ST_RET_WAIT;
          ret_cnt_nx = RET_LOAD;
        end
      end

      ST_RET_WAIT: begin
        stall_f    = 1'b1;
        bubble_d   = 1'b1;
        ret_cnt_nx = ret_cnt_q - 4'd1;
        if (w_exc) begin
          state_nx   = ST_HALTED;
          ret_cnt_nx = '0;
        end else if (ret_cnt_q == 4'd1) begin
          state_nx = ST_RUN;
        end
      end

      ST_HALTED: begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_w  = 1'b1;
        bubble_e = 1'b1;
        bubble_m = 1'b1;
        bubble_d = 1'b0;
        cc_en    = 1'b0;
      end

      default: begin
        state_nx   = ST_RUN;
        ret_cnt_nx = '0;
      end
    endcase
  end

  // Control state register; reset returns to RUN immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_nx;
      ret_cnt_q <= ret_cnt_nx;
    end
  end

  // Saturating stall/bubble performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((bubble_d || bubble_e) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (RET_WAIT_CYCLES=3/CNT_W=32 and
// RET_WAIT_CYCLES=1/CNT_W=4) share one input stream and are compared every
// cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] icode_d, icode_e, icode_m, srcA_d, srcB_d, dstM_e;
  logic       cnd_e;
  logic [2:0] stat_m, stat_w;

  logic        a_sf, a_sd, a_bd, a_be, a_bm, a_sw, a_cc, a_halted;
  logic [1:0]  a_state;
  logic [31:0] a_scnt, a_bcnt;
  logic        b_sf, b_sd, b_bd, b_be, b_bm, b_sw, b_cc, b_halted;
  logic [1:0]  b_state;
  logic [3:0]  b_scnt, b_bcnt;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RET_WAIT_CYCLES(3), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .icode_d(icode_d), .icode_e(icode_e), .icode_m(icode_m),
    .srcA_d(srcA_d), .srcB_d(srcB_d), .dstM_e(dstM_e), .cnd_e(cnd_e),
    .stat_m(stat_m), .stat_w(stat_w),
    .stall_f(a_sf), .stall_d(a_sd), .bubble_d(a_bd), .bubble_e(a_be),
    .bubble_m(a_bm), .stall_w(a_sw), .cc_en(a_cc), .state(a_state),
    .halted(a_halted), .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
  );

  pipe_hazard_ctrl #(.RET_WAIT_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .icode_d(icode_d), .icode_e(icode_e), .icode_m(icode_m),
    .srcA_d(srcA_d), .srcB_d(srcB_d), .dstM_e(dstM_e), .cnd_e(cnd_e),
    .stat_m(stat_m), .stat_w(stat_w),
    .stall_f(b_sf), .stall_d(b_sd), .bubble_d(b_bd), .bubble_e(b_be),
    .bubble_m(b_bm), .stall_w(b_sw), .cc_en(b_cc), .state(b_state),
    .halted(b_halted), .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
  );

  // Reference model: per instance, a halted flag, the number of ret-stall
  // cycles still owed after the current one, and unbounded event counts.
  int          rwc[2] = '{3, 1};
  int          cw[2]  = '{32, 4};
  bit          m_halt[2];
  int          m_owed[2];
  longint unsigned m_sc[2], m_bc[2];

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {stall_f,stall_d,bubble_d,bubble_e,bubble_m,stall_w,cc_en}.
  function automatic logic [6:0] exp_ctl(int k);
    bit lu, mp, rd, mx, wx;
    lu = ((icode_e == 4'h5) || (icode_e == 4'hB)) && (dstM_e != 4'hF) &&
         ((dstM_e == srcA_d) || (dstM_e == srcB_d));
    mp = (icode_e == 4'h7) && !cnd_e;
    rd = (icode_d == 4'h9);
    mx = (stat_m != 3'd1);
    wx = (stat_w != 3'd1);
    if (m_halt[k])
      return 7'b1101110;
    if (m_owed[k] > 0)
      return {1'b1, 1'b0, 1'b1, 1'b0, mx | wx, wx, ~(mx | wx)};
    return {lu | rd, lu, mp | (rd & ~lu), mp | lu, mx | wx, wx, ~(mx | wx)};
  endfunction

  function automatic longint unsigned sat(int k, longint unsigned v);
    longint unsigned mx;
    mx = (64'd1 << cw[k]) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int exp_state(int k);
    return m_halt[k] ? 2 : ((m_owed[k] > 0) ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_halt[k] = 1'b0; m_owed[k] = 0; m_sc[k] = 0; m_bc[k] = 0;
    end
  endtask

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_clock();
    logic [6:0] c;
    bit lu, mp, rd, wx;
    if (rst) begin
      model_reset();
      return;
    end
    lu = exp_ctl(0)[5];
    mp = (icode_e == 4'h7) && !cnd_e;
    rd = (icode_d == 4'h9);
    wx = (stat_w != 3'd1);
    for (int k = 0; k < 2; k++) begin
      c = exp_ctl(k);
      if (c[6]) m_sc[k]++;
      if (c[4] | c[3]) m_bc[k]++;
      if (m_halt[k]) begin
      end else if (wx) begin
        m_halt[k] = 1'b1; m_owed[k] = 0;
      end else if (m_owed[k] > 0) begin
        m_owed[k]--;
      end else if (rd && !lu && !mp) begin
        m_owed[k] = rwc[k] - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a.ctl"},   {a_sf, a_sd, a_bd, a_be, a_bm, a_sw, a_cc}, exp_ctl(0));
    check({tag, ".a.state"}, a_state, exp_state(0));
    check({tag, ".a.halt"},  a_halted, m_halt[0]);
    check({tag, ".a.scnt"},  a_scnt, sat(0, m_sc[0]));
    check({tag, ".a.bcnt"},  a_bcnt, sat(0, m_bc[0]));
    check({tag, ".b.ctl"},   {b_sf, b_sd, b_bd, b_be, b_bm, b_sw, b_cc}, exp_ctl(1));
    check({tag, ".b.state"}, b_state, exp_state(1));
    check({tag, ".b.halt"},  b_halted, m_halt[1]);
    check({tag, ".b.scnt"},  b_scnt, sat(1, m_sc[1]));
    check({tag, ".b.bcnt"},  b_bcnt, sat(1, m_bc[1]));
  endtask

  // Inputs are driven 1 ns after a rising edge; outputs are checked 4 ns later.
  task automatic step(input string tag);
    #4;
    check_all(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic nop_inputs();
    icode_d = 4'h1; icode_e = 4'h1; icode_m = 4'h1;
    srcA_d = 4'hF; srcB_d = 4'hF; dstM_e = 4'hF; cnd_e = 1'b1;
    stat_m = 3'd1; stat_w = 3'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step("rst");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    nop_inputs();
    model_reset();
    @(posedge clk); #1;
    step("rst0");
    rst = 1'b0;

    // Load-use stall.
    icode_e = 4'h5; dstM_e = 4'h3; srcA_d = 4'h3;
    step("lu");
    check("lu.a.stall_f", a_sf, 1'b1);
    nop_inputs();
    step("lu_clr");

    // Mispredicted jump.
    icode_e = 4'h7; cnd_e = 1'b0;
    step("mp");
    nop_inputs();
    step("mp_clr");

    // Single ret then nops: three stall cycles in dut_a, one in dut_b.
    icode_d = 4'h9;
    step("ret");
    nop_inputs();
    for (int i = 0; i < 4; i++) step("ret_wait");

    // Ret held in D behind a two-cycle load-use, then released.
    icode_d = 4'h9; icode_e = 4'h5; dstM_e = 4'h3; srcA_d = 4'h3;
    step("ret_lu"); step("ret_lu");
    icode_e = 4'h1;
    step("ret_go");
    icode_d = 4'h1;
    for (int i = 0; i < 3; i++) step("ret_lu_tail");

    // Ret with mispredict: no RET_WAIT entry.
    icode_d = 4'h9; icode_e = 4'h7; cnd_e = 1'b0;
    step("ret_mp");
    nop_inputs();
    step("ret_mp_clr");

    // Memory then write-back exception, then sticky halt.
    stat_m = 3'd3;
    step("m_exc");
    stat_m = 3'd1; stat_w = 3'd3;
    step("w_exc");
    nop_inputs();
    for (int i = 0; i < 10; i++) step("halt");
    check("halt.a.halted", a_halted, 1'b1);
    do_reset();

    // Continuous fetch stall: the 4-bit counter saturates at 15.
    icode_d = 4'h9;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat.b.scnt", b_scnt, 64'd15);

    // Asynchronous reset in the middle of RET_WAIT.
    do_reset();
    icode_d = 4'h9;
    step("aret");
    nop_inputs();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.a.state", a_state, 0);
    check("arst.a.scnt",  a_scnt, 0);
    check("arst.a.bcnt",  a_bcnt, 0);
    check("arst.b.scnt",  b_scnt, 0);
    #1;
    check_all("arst");
    @(posedge clk); model_clock(); #1;
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      icode_d = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: icode_e = 4'h5;
        1: icode_e = 4'hB;
        2: icode_e = 4'h7;
        default: icode_e = 4'($urandom_range(0, 15));
      endcase
      icode_m = 4'($urandom_range(0, 15));
      dstM_e  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(1, 3));
      srcA_d  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(1, 3));
      srcB_d  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(1, 3));
      cnd_e   = 1'($urandom_range(0, 1));
      stat_m  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      stat_w  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      if (m_halt[0] && ($urandom_range(0, 7) == 0))
        do_reset();
      else
        step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
